// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, controller state encoding and default widths.
// Used by the master controller and the slave adaptor.
package axi4_lite_pkg;

  localparam int unsigned ADDR_WIDTH_DEF     = 32;
  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_RESP
  } state_t;

endpackage

// File: rtl/axi4_lite_master_controller_if.sv
// AXI4-Lite bus bundle between the master controller and a slave.
// Signal suffixes are from the master's point of view.
interface axi4_lite_master_controller_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr_out;
  logic [2:0]              awprot_out;
  logic                    awvalid_out;
  logic                    awready_in;
  logic [DATA_WIDTH-1:0]   wdata_out;
  logic [DATA_WIDTH/8-1:0] wstrb_out;
  logic                    wvalid_out;
  logic                    wready_in;
  logic [1:0]              bresp_in;
  logic                    bvalid_in;
  logic                    bready_out;
  logic [ADDR_WIDTH-1:0]   araddr_out;
  logic [2:0]              arprot_out;
  logic                    arvalid_out;
  logic                    arready_in;
  logic [DATA_WIDTH-1:0]   rdata_in;
  logic [1:0]              rresp_in;
  logic                    rvalid_in;
  logic                    rready_out;

  modport master (
    output awaddr_out, awprot_out, awvalid_out, input awready_in,
    output wdata_out, wstrb_out, wvalid_out, input wready_in,
    input  bresp_in, bvalid_in, output bready_out,
    output araddr_out, arprot_out, arvalid_out, input arready_in,
    input  rdata_in, rresp_in, rvalid_in, output rready_out
  );

  modport slave (
    input  awaddr_out, awprot_out, awvalid_out, output awready_in,
    input  wdata_out, wstrb_out, wvalid_out, output wready_in,
    output bresp_in, bvalid_in, input bready_out,
    input  araddr_out, arprot_out, arvalid_out, output arready_in,
    output rdata_in, rresp_in, rvalid_in, input rready_out
  );
endinterface

// File: rtl/axi4_lite_watchdog.sv
// Handshake watchdog: counts waiting cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES cycles have been spent waiting.
module axi4_lite_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear_in,
  input  logic enable_in,
  output logic expired_out
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The cycle that observes cnt == TIMEOUT_CYCLES-1 is the last waiting cycle.
  assign expired_out = (32'(cnt_q) == TIMEOUT_CYCLES - 1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_in) begin
      cnt_d = '0;
    end else if (enable_in && !expired_out) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axi4_lite_master_controller.sv
// Single-outstanding AXI4-Lite master: turns one command into AW/W/B or AR/R handshakes.
// Optional hung-slave watchdog enabled by defining AXI4_LITE_TIMEOUT_EN.
module axi4_lite_master_controller
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid_in,
  output logic                    cmd_ready_out,
  input  logic                    cmd_write_in,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_in,
  input  logic [2:0]              cmd_prot_in,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic                    rsp_write_out,
  output logic [1:0]              rsp_resp_out,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic                    rsp_timeout_out,
  axi4_lite_master_controller_if.master bus
);

  state_t                  state_q, state_d;
  logic                    ready_en_q, ready_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              prot_q, prot_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    write_q, write_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic [1:0]              resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    timeout_q, timeout_d;
  logic                    wd_expired;

`ifdef AXI4_LITE_TIMEOUT_EN
  logic wd_clear, wd_enable;

  assign wd_clear  = (state_d != state_q);
  assign wd_enable = (state_q == ST_WRITE) || (state_q == ST_WRESP) ||
                     (state_q == ST_RADDR) || (state_q == ST_RDATA);

  axi4_lite_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .clear_in    (wd_clear),
    .enable_in   (wd_enable),
    .expired_out (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_expired         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ready_en_d = 1'b1;
    addr_d     = addr_q;
    prot_d     = prot_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    write_d    = write_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    timeout_d  = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_in && ready_en_q) begin
          addr_d    = cmd_addr_in;
          prot_d    = cmd_prot_in;
          wdata_d   = cmd_wdata_in;
          wstrb_d   = cmd_wstrb_in;
          write_d   = cmd_write_in;
          timeout_d = 1'b0;
          if (cmd_write_in) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            state_d   = ST_RADDR;
          end
        end
      end
      ST_WRITE: begin
        // AW and W retire independently; leave once neither is still pending.
        if (awvalid_q && bus.awready_in) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready_in)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)     state_d   = ST_WRESP;
      end
      ST_WRESP: begin
        if (bus.bvalid_in) begin
          resp_d  = bus.bresp_in;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_RADDR: begin
        if (bus.arready_in) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (bus.rvalid_in) begin
          resp_d  = bus.rresp_in;
          rdata_d = bus.rdata_in;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Hung-slave abort: drops pending valids, which a compliant master would never do.
    if (wd_expired && (state_q != ST_IDLE) && (state_q != ST_RESP)) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      resp_d    = RESP_DECERR;
      rdata_d   = '0;
      timeout_d = 1'b1;
      state_d   = ST_RESP;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
      addr_q     <= '0;
      prot_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      write_q    <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= ready_en_d;
      addr_q     <= addr_d;
      prot_q     <= prot_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      write_q    <= write_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
    end
  end

  // ready_en_q keeps cmd_ready_out low until the first edge after reset release.
  assign cmd_ready_out   = ready_en_q && (state_q == ST_IDLE);
  assign rsp_valid_out   = (state_q == ST_RESP);
  assign rsp_write_out   = write_q;
  assign rsp_resp_out    = resp_q;
  assign rsp_rdata_out   = rdata_q;
  assign rsp_timeout_out = timeout_q;

  assign bus.awaddr_out  = addr_q;
  assign bus.awprot_out  = prot_q;
  assign bus.awvalid_out = awvalid_q;
  assign bus.wdata_out   = wdata_q;
  assign bus.wstrb_out   = wstrb_q;
  assign bus.wvalid_out  = wvalid_q;
  assign bus.bready_out  = (state_q == ST_WRESP);
  assign bus.araddr_out  = addr_q;
  assign bus.arprot_out  = prot_q;
  assign bus.arvalid_out = (state_q == ST_RADDR);
  assign bus.rready_out  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_axi4_lite_master_controller.sv
// Directed bench for axi4_lite_master_controller; the bench acts as the AXI4-Lite slave.
// Define AXI4_LITE_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=8.
module tb_axi4_lite_master_controller;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef AXI4_LITE_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 256;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_valid_in, cmd_ready_out, cmd_write_in;
  logic [AW-1:0] cmd_addr_in;
  logic [2:0]    cmd_prot_in;
  logic [DW-1:0] cmd_wdata_in;
  logic [3:0]    cmd_wstrb_in;
  logic          rsp_valid_out, rsp_ready_in, rsp_write_out, rsp_timeout_out;
  logic [1:0]    rsp_resp_out;
  logic [DW-1:0] rsp_rdata_out;

  axi4_lite_master_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

  axi4_lite_master_controller #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .cmd_valid_in    (cmd_valid_in),
    .cmd_ready_out   (cmd_ready_out),
    .cmd_write_in    (cmd_write_in),
    .cmd_addr_in     (cmd_addr_in),
    .cmd_prot_in     (cmd_prot_in),
    .cmd_wdata_in    (cmd_wdata_in),
    .cmd_wstrb_in    (cmd_wstrb_in),
    .rsp_valid_out   (rsp_valid_out),
    .rsp_ready_in    (rsp_ready_in),
    .rsp_write_out   (rsp_write_out),
    .rsp_resp_out    (rsp_resp_out),
    .rsp_rdata_out   (rsp_rdata_out),
    .rsp_timeout_out (rsp_timeout_out),
    .bus             (axi_if.master)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] prot,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    cmd_valid_in = 1'b1;
    cmd_write_in = wr;
    cmd_addr_in  = addr;
    cmd_prot_in  = prot;
    cmd_wdata_in = wdata;
    cmd_wstrb_in = wstrb;
    step();
    cmd_valid_in = 1'b0;
    cmd_addr_in  = '0;
    cmd_wdata_in = '0;
    cmd_wstrb_in = '0;
  endtask

  int aw_cnt, w_cnt, ar_cnt, guard;

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    aresetn = 1'b0;
    cmd_valid_in = 0; cmd_write_in = 0; cmd_addr_in = '0; cmd_prot_in = '0;
    cmd_wdata_in = '0; cmd_wstrb_in = '0; rsp_ready_in = 0;
    axi_if.awready_in = 0; axi_if.wready_in = 0; axi_if.bvalid_in = 0; axi_if.bresp_in = 0;
    axi_if.arready_in = 0; axi_if.rvalid_in = 0; axi_if.rresp_in = 0; axi_if.rdata_in = '0;

    // Reset state
    #2;
    chk("rst_cmd_ready", cmd_ready_out, 0);
    chk("rst_awvalid", axi_if.awvalid_out, 0);
    chk("rst_rsp_valid", rsp_valid_out, 0);
    chk("rst_awaddr", axi_if.awaddr_out, 0);
    step(); step();
    #3 aresetn = 1'b1;
    chk("rel_cmd_ready_pre", cmd_ready_out, 0);
    step();
    chk("rel_cmd_ready", cmd_ready_out, 1);

    // Zero-wait write
    axi_if.awready_in = 1; axi_if.wready_in = 1; axi_if.arready_in = 1;
    issue(1'b1, 32'd16, 3'd4, 32'hF0B4A596, 4'b1011);
    chk("wr_awvalid_c1", axi_if.awvalid_out, 1);
    chk("wr_wvalid_c1", axi_if.wvalid_out, 1);
    chk("wr_awaddr", axi_if.awaddr_out, 16);
    chk("wr_awprot", axi_if.awprot_out, 4);
    chk("wr_wdata", axi_if.wdata_out, 32'hF0B4A596);
    chk("wr_wstrb", axi_if.wstrb_out, 4'b1011);
    chk("wr_cmd_ready_c1", cmd_ready_out, 0);
    chk("wr_arvalid_c1", axi_if.arvalid_out, 0);
    step();
    chk("wr_awvalid_c2", axi_if.awvalid_out, 0);
    chk("wr_wvalid_c2", axi_if.wvalid_out, 0);
    chk("wr_bready_c2", axi_if.bready_out, 1);
    chk("wr_rsp_valid_c2", rsp_valid_out, 0);
    axi_if.bvalid_in = 1; axi_if.bresp_in = 2'b00;
    step();
    axi_if.bvalid_in = 0;
    chk("wr_rsp_valid_c3", rsp_valid_out, 1);
    chk("wr_rsp_resp", rsp_resp_out, 2'b00);
    chk("wr_rsp_write", rsp_write_out, 1);
    chk("wr_rsp_rdata", rsp_rdata_out, 0);
    chk("wr_rsp_timeout", rsp_timeout_out, 0);
    chk("wr_bready_c3", axi_if.bready_out, 0);
    rsp_ready_in = 1;
    step();
    rsp_ready_in = 0;
    chk("wr_rsp_valid_c4", rsp_valid_out, 0);
    chk("wr_cmd_ready_c4", cmd_ready_out, 1);

    // Zero-wait read
    issue(1'b0, 32'd16, 3'd2, 32'h0, 4'h0);
    chk("rd_arvalid_c1", axi_if.arvalid_out, 1);
    chk("rd_araddr", axi_if.araddr_out, 16);
    chk("rd_arprot", axi_if.arprot_out, 2);
    chk("rd_awvalid_c1", axi_if.awvalid_out, 0);
    step();
    chk("rd_arvalid_c2", axi_if.arvalid_out, 0);
    chk("rd_rready_c2", axi_if.rready_out, 1);
    axi_if.rvalid_in = 1; axi_if.rdata_in = 32'hF0B4A596; axi_if.rresp_in = 2'b00;
    step();
    axi_if.rvalid_in = 0; axi_if.rdata_in = '0;
    chk("rd_rsp_valid_c3", rsp_valid_out, 1);
    chk("rd_rsp_rdata", rsp_rdata_out, 32'hF0B4A596);
    chk("rd_rsp_resp", rsp_resp_out, 2'b00);
    chk("rd_rsp_write", rsp_write_out, 0);
    rsp_ready_in = 1;
    step();
    rsp_ready_in = 0;
    chk("rd_cmd_ready_c4", cmd_ready_out, 1);

    // Skewed write: AW accepted 4 cycles after W
    axi_if.awready_in = 0; axi_if.wready_in = 1;
    issue(1'b1, 32'h20, 3'd1, 32'h11223344, 4'b1111);
    aw_cnt = 0; w_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) axi_if.awready_in = 1;
      aw_cnt += int'(axi_if.awvalid_out);
      w_cnt  += int'(axi_if.wvalid_out);
      if (c == 4) chk("skw_bready_wait", axi_if.bready_out, 0);
      step();
    end
    chk("skw_aw_cycles", aw_cnt, 5);
    chk("skw_w_cycles", w_cnt, 1);
    chk("skw_awvalid_done", axi_if.awvalid_out, 0);
    chk("skw_bready", axi_if.bready_out, 1);
    axi_if.bvalid_in = 1; axi_if.bresp_in = 2'b01;
    step();
    axi_if.bvalid_in = 0;
    chk("skw_bready_after", axi_if.bready_out, 0);
    chk("skw_rsp_valid", rsp_valid_out, 1);
    chk("skw_rsp_resp", rsp_resp_out, 2'b01);
    rsp_ready_in = 1;
    step();
    rsp_ready_in = 0;

    // Slave error with response backpressure and a read command waiting
    axi_if.awready_in = 1; axi_if.wready_in = 1;
    issue(1'b1, 32'h30, 3'd0, 32'hDEADBEEF, 4'b0001);
    step();
    axi_if.bvalid_in = 1; axi_if.bresp_in = 2'b10;
    step();
    axi_if.bvalid_in = 0; axi_if.bresp_in = 2'b00;
    issue_hold: begin
      cmd_valid_in = 1; cmd_write_in = 0; cmd_addr_in = 32'h99;
    end
    for (int c = 0; c < 6; c++) begin
      chk("bp_rsp_valid", rsp_valid_out, 1);
      chk("bp_rsp_resp", rsp_resp_out, 2'b10);
      chk("bp_rsp_write", rsp_write_out, 1);
      chk("bp_cmd_ready", cmd_ready_out, 0);
      step();
    end
    cmd_valid_in = 0;
    rsp_ready_in = 1;
    step();
    rsp_ready_in = 0;
    chk("bp_rsp_valid_rel", rsp_valid_out, 0);
    chk("bp_cmd_ready_rel", cmd_ready_out, 1);
    chk("bp_arvalid_rel", axi_if.arvalid_out, 0);

    // Reset during RDATA
    axi_if.arready_in = 1;
    issue(1'b0, 32'h44, 3'd3, 32'h0, 4'h0);
    step();
    chk("mr_rready_pre", axi_if.rready_out, 1);
    aresetn = 1'b0;
    #1;
    chk("mr_rready", axi_if.rready_out, 0);
    chk("mr_arvalid", axi_if.arvalid_out, 0);
    chk("mr_cmd_ready", cmd_ready_out, 0);
    chk("mr_araddr", axi_if.araddr_out, 0);
    chk("mr_rsp_valid", rsp_valid_out, 0);
    #3 aresetn = 1'b1;
    axi_if.rvalid_in = 1; axi_if.rdata_in = 32'hBAD0BAD0;
    step();
    chk("mr_stray_rsp_valid", rsp_valid_out, 0);
    chk("mr_stray_rready", axi_if.rready_out, 0);
    chk("mr_cmd_ready_rel", cmd_ready_out, 1);
    axi_if.rvalid_in = 0;
    issue(1'b0, 32'h48, 3'd0, 32'h0, 4'h0);
    chk("mr2_araddr", axi_if.araddr_out, 32'h48);
    step();
    axi_if.rvalid_in = 1; axi_if.rdata_in = 32'h12345678; axi_if.rresp_in = 2'b01;
    step();
    axi_if.rvalid_in = 0;
    chk("mr2_rsp_valid", rsp_valid_out, 1);
    chk("mr2_rsp_rdata", rsp_rdata_out, 32'h12345678);
    chk("mr2_rsp_resp", rsp_resp_out, 2'b01);
    rsp_ready_in = 1;
    step();
    rsp_ready_in = 0;

`ifdef AXI4_LITE_TIMEOUT_EN
    // Hung slave: AR never accepted
    axi_if.arready_in = 0;
    issue(1'b0, 32'h50, 3'd0, 32'h0, 4'h0);
    ar_cnt = 0; guard = 0;
    while (axi_if.arvalid_out && guard < 40) begin
      ar_cnt++;
      guard++;
      step();
    end
    chk("to_ar_cycles", ar_cnt, 8);
    chk("to_rsp_valid", rsp_valid_out, 1);
    chk("to_rsp_resp", rsp_resp_out, 2'b11);
    chk("to_rsp_timeout", rsp_timeout_out, 1);
    chk("to_rsp_rdata", rsp_rdata_out, 0);
    rsp_ready_in = 1;
    step();
    rsp_ready_in = 0;
    chk("to_cmd_ready", cmd_ready_out, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
